bin2bcd_stream: RTL

- Sequential double-dabble binary-to-BCD converter with a valid/ready handshake on both input and output.
- Generalises the fixed load-pulse converter: any binary width, any digit count, optional signed (two's-complement) input and an exact overflow flag.
- Sits between binary datapath producers and the display/decimal-output logic.

---
 rtl/bin2bcd_stream_if.sv | 45 ++++
 rtl/bin2bcd_stream.sv | 138 +++++++++++++
 2 files changed

// File: rtl/bin2bcd_stream_if.sv
// bin2bcd_stream_if: the handshake and data bundle for bin2bcd_stream.
//   Input side:  in_valid, in_ready, bin_in
//   Output side: out_valid, out_ready, bcd_out, sign_out, overflow
//   Status:      busy
// Modports:
//   slave  - the converter (accepts words, produces results)
//   master - the producer/consumer driving the converter
interface bin2bcd_stream_if #(
    parameter int unsigned BIN_WIDTH = 32,
    parameter int unsigned DIGITS    = 10
);
    logic                      in_valid;
    logic                      in_ready;
    logic [BIN_WIDTH-1:0]      bin_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIGITS-1:0][3:0]    bcd_out;
    logic                      sign_out;
    logic                      overflow;
    logic                      busy;

    modport slave (
        input  in_valid,
        input  bin_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bcd_out,
        output sign_out,
        output overflow,
        output busy
    );

    modport master (
        output in_valid,
        output bin_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bcd_out,
        input  sign_out,
        input  overflow,
        input  busy
    );
endinterface

// File: rtl/bin2bcd_stream.sv
// bin2bcd_stream: sequential double-dabble binary-to-BCD converter with valid/ready
// handshakes on both sides. One shift per clock; BIN_WIDTH shifts per word.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - bin2bcd_stream_if slave modport:
//          in_valid/in_ready/bin_in        word input handshake
//          out_valid/out_ready/bcd_out     result handshake (digit 0 = least significant)
//          sign_out                        1 = negative input (SIGNED_MODE only)
//          overflow                        magnitude >= 10^DIGITS
//          busy                            conversion in progress
module bin2bcd_stream #(
    parameter int unsigned BIN_WIDTH   = 32,
    parameter int unsigned DIGITS      = 10,
    parameter bit          SIGNED_MODE = 1'b0
) (
    input logic              clk,
    input logic              rst,
    bin2bcd_stream_if.slave  bus
);
    localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);
    localparam int unsigned BcdW = DIGITS * 4;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StConvert = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [BIN_WIDTH-1:0] mag_q, mag_d;
    logic [BcdW-1:0]      acc_q, acc_d;
    logic                 ovf_acc_q, ovf_acc_d;
    logic                 sign_acc_q, sign_acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BcdW-1:0]      bcd_q, bcd_d;
    logic                 sign_q, sign_d;
    logic                 ovf_q, ovf_d;

    logic                 neg_in;
    logic [BIN_WIDTH-1:0] mag_in;
    logic [BcdW-1:0]      adj;
    logic [3:0]           dig;
    logic [BcdW-1:0]      acc_shift;
    logic [BIN_WIDTH-1:0] mag_shift;
    logic                 carry;

    // Magnitude capture; the most negative value maps onto 2^(BIN_WIDTH-1) naturally.
    always_comb begin
        neg_in = SIGNED_MODE && bus.bin_in[BIN_WIDTH-1];
        mag_in = neg_in ? (~bus.bin_in + {{(BIN_WIDTH-1){1'b0}}, 1'b1}) : bus.bin_in;
    end

    // One double-dabble iteration: add-3 to digits >= 5, then shift {digits, magnitude}.
    always_comb begin
        adj = '0;
        dig = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig = acc_q[4*i +: 4];
            adj[4*i +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
        end
        carry     = adj[BcdW-1];
        acc_shift = {adj[BcdW-2:0], mag_q[BIN_WIDTH-1]};
        mag_shift = {mag_q[BIN_WIDTH-2:0], 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        acc_d      = acc_q;
        ovf_acc_d  = ovf_acc_q;
        sign_acc_d = sign_acc_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        ovf_d      = ovf_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    mag_d      = mag_in;
                    sign_acc_d = neg_in;
                    acc_d      = '0;
                    ovf_acc_d  = 1'b0;
                    cnt_d      = CntW'(BIN_WIDTH);
                    state_d    = StConvert;
                end
            end
            StConvert: begin
                mag_d     = mag_shift;
                acc_d     = acc_shift;
                // A bit leaving the top digit means the value reached 10^DIGITS; sticky.
                ovf_acc_d = ovf_acc_q | carry;
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    bcd_d   = acc_shift;
                    sign_d  = sign_acc_q;
                    ovf_d   = ovf_acc_q | carry;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            mag_q      <= '0;
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
            sign_acc_q <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            acc_q      <= acc_d;
            ovf_acc_q  <= ovf_acc_d;
            sign_acc_q <= sign_acc_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q == StConvert);
    assign bus.out_valid = (state_q == StDone);
    assign bus.bcd_out   = bcd_q;
    assign bus.sign_out  = sign_q;
    assign bus.overflow  = ovf_q;
endmodule
